// File: rtl/lut_burst_arbiter.sv
// -----------------------------------------------------------------------------
// lut_burst_arbiter
//
// Round-robin arbiter that gives one of two requesters ownership of a
// synchronous LUT/ROM for one address burst. The winner's start address and
// length are latched at the grant edge. One address is then issued per cycle
// while en is high. Each returned word is registered and tagged with the
// owning requester and an end-of-burst flag.
//
// Ports
//   clk_sys     : system clock, rising edge
//   rst         : asynchronous active-high reset
//   en          : allows address issue while a burst is running
//   req[1:0]    : burst request per requester (bit0 = requester 0)
//   start_adr0/1: burst start address per requester
//   len0/1      : burst length minus one per requester
//   gnt[1:0]    : one-hot grant, held from grant until the burst has drained
//   rom_en      : LUT read enable
//   rom_adr     : LUT read address
//   rom_data    : LUT read data, valid the cycle after rom_en
//   data_out    : registered LUT word
//   data_valid  : data_out valid, one-cycle pulse per issued address
//   data_id     : requester index owning data_out
//   data_last   : final word of the burst, coincident with data_valid
//   busy        : high whenever the FSM is not idle
//
// Timing per issued word:
//   cycle N   : rom_en/rom_adr registered outputs
//   cycle N+1 : rom_data valid at the LUT output
//   cycle N+2 : data_out/data_valid
// -----------------------------------------------------------------------------
//
// state | meaning
// ------+----------------------------------------------------------------------
// IDLE  | no owner; any request is granted on the next edge
// READ  | issuing start+cnt for cnt = 0..len, one per cycle while en is high
// DRAIN | all addresses issued; waits until the last word leaves data_out
//
module lut_burst_arbiter #(
   parameter int BITWIDTH_ADR  = 6,
   parameter int BITWIDTH_DATA = 16
) (
   input  logic                     clk_sys,
   input  logic                     rst,
   input  logic                     en,
   input  logic [1:0]               req,
   input  logic [BITWIDTH_ADR-1:0]  start_adr0,
   input  logic [BITWIDTH_ADR-1:0]  start_adr1,
   input  logic [BITWIDTH_ADR-1:0]  len0,
   input  logic [BITWIDTH_ADR-1:0]  len1,
   output logic [1:0]               gnt,
   output logic                     rom_en,
   output logic [BITWIDTH_ADR-1:0]  rom_adr,
   input  logic [BITWIDTH_DATA-1:0] rom_data,
   output logic [BITWIDTH_DATA-1:0] data_out,
   output logic                     data_valid,
   output logic                     data_id,
   output logic                     data_last,
   output logic                     busy
);

   localparam logic [BITWIDTH_ADR-1:0] ADR_ONE = BITWIDTH_ADR'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                    state;
   logic [BITWIDTH_ADR-1:0]   cnt;
   logic [BITWIDTH_ADR-1:0]   start_q;
   logic [BITWIDTH_ADR-1:0]   len_q;
   logic                      owner;
   logic                      prio;       // requester favoured on a tie
   logic                      rom_last;   // rom_adr is the burst's final address

   logic                      p_valid;    // rom_data carries a requested word
   logic                      p_last;

   logic                      win;
   logic [BITWIDTH_ADR-1:0]   start_sel;
   logic [BITWIDTH_ADR-1:0]   len_sel;

   // A lone request always wins. On a tie, the requester that was not
   // served last wins.
   always_comb begin
      win = 1'b0;
      if (req == 2'b11) begin
         win = prio;
      end else begin
         win = req[1];
      end
      start_sel = win ? start_adr1 : start_adr0;
      len_sel   = win ? len1 : len0;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         start_q  <= '0;
         len_q    <= '0;
         owner    <= 1'b0;
         prio     <= 1'b0;
         gnt      <= 2'b00;
         rom_en   <= 1'b0;
         rom_adr  <= '0;
         rom_last <= 1'b0;
      end else begin
         rom_en   <= 1'b0;
         rom_last <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  owner   <= win;
                  start_q <= start_sel;
                  len_q   <= len_sel;
                  cnt     <= '0;
                  gnt     <= win ? 2'b10 : 2'b01;
                  state   <= READ;
               end
            end
            READ: begin
               // When en is low, cnt holds, so issue resumes at the same address.
               if (en) begin
                  rom_en  <= 1'b1;
                  rom_adr <= start_q + cnt;   // wraps modulo 2^BITWIDTH_ADR
                  if (cnt == len_q) begin
                     rom_last <= 1'b1;
                     cnt      <= '0;
                     state    <= DRAIN;
                  end else begin
                     cnt <= cnt + ADR_ONE;
                  end
               end
            end
            DRAIN: begin
               // Leave one cycle after the last word is presented, so that
               // gnt covers the whole burst including its final word.
               if (data_valid && data_last) begin
                  gnt   <= 2'b00;
                  prio  <= ~owner;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Return path: a two-stage shift of the issue tags that tracks the LUT's
   // one-cycle read latency plus the output register. Only words that were
   // actually issued produce data_valid. Reset clears the in-flight tags, so
   // an aborted burst emits nothing.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         p_valid    <= 1'b0;
         p_last     <= 1'b0;
         data_valid <= 1'b0;
         data_last  <= 1'b0;
         data_id    <= 1'b0;
         data_out   <= '0;
      end else begin
         p_valid    <= rom_en;
         p_last     <= rom_en & rom_last;
         data_valid <= p_valid;
         data_last  <= p_valid & p_last;
         if (p_valid) begin
            data_out <= rom_data;
            data_id  <= owner;
         end
      end
   end

endmodule

// File: tb/tb_lut_burst_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lut_burst_arbiter
//
// Bench for lut_burst_arbiter. A synchronous LUT with random contents is
// modelled here. Each burst is compared against a transaction-level model.
// The model predicts the winner from a round-robin pointer kept here. The
// expected address list is start+i modulo 64, and each expected word is the
// LUT content at that address. The bench also checks issue-to-valid latency,
// the last-word flag, grant stability and the burst duration.
// -----------------------------------------------------------------------------
module tb_lut_burst_arbiter;

   localparam int AW = 6;
   localparam int DW = 16;

   logic          clk_sys = 1'b0;
   logic          rst;
   logic          en;
   logic [1:0]    req;
   logic [AW-1:0] start_adr0, start_adr1, len0, len1;
   logic [1:0]    gnt;
   logic          rom_en;
   logic [AW-1:0] rom_adr;
   logic [DW-1:0] rom_data;
   logic [DW-1:0] data_out;
   logic          data_valid, data_id, data_last, busy;

   lut_burst_arbiter #(.BITWIDTH_ADR(AW), .BITWIDTH_DATA(DW)) dut (
      .clk_sys    (clk_sys),
      .rst        (rst),
      .en         (en),
      .req        (req),
      .start_adr0 (start_adr0),
      .start_adr1 (start_adr1),
      .len0       (len0),
      .len1       (len1),
      .gnt        (gnt),
      .rom_en     (rom_en),
      .rom_adr    (rom_adr),
      .rom_data   (rom_data),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_id    (data_id),
      .data_last  (data_last),
      .busy       (busy)
   );

   always #5 clk_sys = ~clk_sys;

   logic [DW-1:0] lut [64];

   // Synchronous LUT. When the LUT is not read, its output carries random
   // junk, so any word presented without a matching issue shows up as bad data.
   always @(posedge clk_sys) begin
      rom_data <= rom_en ? lut[rom_adr] : DW'($urandom);
   end

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int prio_m  = 0;

   int            iss_cyc_q[$];
   int            iss_all[$];
   logic [AW-1:0] got_adr[$];
   logic [DW-1:0] got_data[$];
   bit            got_id[$];
   bit            got_last[$];
   bit            gnt_bad;
   logic [1:0]    gnt_exp;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic clear_q();
      iss_cyc_q.delete();
      iss_all.delete();
      got_adr.delete();
      got_data.delete();
      got_id.delete();
      got_last.delete();
      gnt_bad = 1'b0;
   endtask

   // Advance to the next falling edge and record what the DUT shows there.
   task automatic step();
      int c0;
      @(negedge clk_sys);
      cyc++;
      if (rom_en) begin
         got_adr.push_back(rom_adr);
         iss_cyc_q.push_back(cyc);
         iss_all.push_back(cyc);
      end
      if (data_valid) begin
         if (iss_cyc_q.size() == 0) begin
            chk("spurious_valid", 1, 0);
         end else begin
            c0 = iss_cyc_q.pop_front();
            chk("valid_latency", cyc - c0, 2);
         end
         got_data.push_back(data_out);
         got_id.push_back(data_id);
         got_last.push_back(data_last);
      end
      if (busy && (gnt !== gnt_exp)) gnt_bad = 1'b1;
   endtask

   task automatic check_all_zero(input string ctx);
      chk({ctx, "_gnt"},        gnt, 0);
      chk({ctx, "_rom_en"},     rom_en, 0);
      chk({ctx, "_rom_adr"},    rom_adr, 0);
      chk({ctx, "_data_out"},   data_out, 0);
      chk({ctx, "_data_valid"}, data_valid, 0);
      chk({ctx, "_data_id"},    data_id, 0);
      chk({ctx, "_data_last"},  data_last, 0);
      chk({ctx, "_busy"},       busy, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 2'b00;
      en  = 1'b0;
      step();
      step();
      rst = 1'b0;
      prio_m = 0;
      clear_q();
   endtask

   // Run one burst, starting from a falling edge in IDLE. The task returns
   // at the falling edge of the single IDLE cycle that follows the burst.
   // en_mode: 0 = en always high, 1 = random en,
   //          2 = en low for three edges after the second issued address.
   task automatic run_burst(input logic [1:0] r, input logic [AW-1:0] s0, input logic [AW-1:0] l0,
                            input logic [AW-1:0] s1, input logic [AW-1:0] l1,
                            input int en_mode, input bit scramble);
      int            w, busy_n, stall, n;
      bit            stalled, done;
      logic [AW-1:0] s, l, ea;
      w = (r == 2'b11) ? prio_m : (r[1] ? 1 : 0);
      s = (w == 1) ? s1 : s0;
      l = (w == 1) ? l1 : l0;
      n = int'(l) + 1;
      req = r; start_adr0 = s0; len0 = l0; start_adr1 = s1; len1 = l1;
      en = (en_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      clear_q();
      gnt_exp = (w == 1) ? 2'b10 : 2'b01;
      step();
      chk("grant", gnt, gnt_exp);
      chk("busy_on", busy, 1);
      busy_n  = 1;
      stall   = 0;
      stalled = 1'b0;
      done    = 1'b0;
      for (int t = 0; t < 400; t++) begin
         if (scramble) begin
            req        = 2'($urandom);
            start_adr0 = AW'($urandom);
            start_adr1 = AW'($urandom);
            len0       = AW'($urandom);
            len1       = AW'($urandom);
         end
         if (en_mode == 1) begin
            en = ($urandom_range(0, 3) != 0);
         end else if (en_mode == 2) begin
            if (!stalled && got_adr.size() == 2) begin
               en = 1'b0; stall = 2; stalled = 1'b1;
            end else if (stall > 0) begin
               en = 1'b0; stall--;
            end else begin
               en = 1'b1;
            end
         end
         step();
         if (!busy) begin
            done = 1'b1;
            break;
         end
         busy_n++;
      end
      req = 2'b00;
      if (!done) chk("burst_timeout", 1, 0);
      chk("n_issue", got_adr.size(), n);
      chk("n_data", got_data.size(), n);
      for (int i = 0; i < n; i++) begin
         ea = s + AW'(i);
         if (i < got_adr.size()) chk("adr", got_adr[i], ea);
         if (i < got_data.size()) begin
            chk("data", got_data[i], lut[ea]);
            chk("id", got_id[i], w);
            chk("last", got_last[i], (i == n - 1));
         end
      end
      chk("gnt_stable", gnt_bad, 0);
      chk("gnt_clear", gnt, 0);
      if (en_mode == 0) chk("busy_cycles", busy_n, n + 3);
      if (en_mode == 2 && iss_all.size() >= 3) chk("stall_gap", iss_all[2] - iss_all[1], 4);
      prio_m = 1 - w;
   endtask

   initial begin
      int nv;
      for (int i = 0; i < 64; i++) lut[i] = DW'($urandom);
      rst = 1'b1; en = 1'b0; req = 2'b00;
      start_adr0 = '0; start_adr1 = '0; len0 = '0; len1 = '0;
      gnt_exp = 2'b00;
      clear_q();

      step();
      check_all_zero("reset");
      step();
      rst = 1'b0;

      // Requester 0: addresses 4..7
      run_burst(2'b01, 6'd4, 6'd3, 6'd20, 6'd2, 0, 1'b0);

      // After reset the pointer favours 0; a held tie alternates 0,1,0,1
      do_reset();
      for (int k = 0; k < 4; k++) begin
         run_burst(2'b11, AW'(8 * k), 6'd2, AW'(8 * k + 40), 6'd1, 0, 1'b0);
      end

      // Wrap past the top of the address space
      run_burst(2'b10, 6'd0, 6'd0, 6'd62, 6'd3, 0, 1'b0);

      // en stalls for three cycles after address 5
      run_burst(2'b01, 6'd4, 6'd3, 6'd0, 6'd0, 2, 1'b0);

      // One-word burst
      run_burst(2'b01, 6'd33, 6'd0, 6'd0, 6'd5, 0, 1'b0);

      // Random back-to-back bursts with changing inputs mid-burst
      for (int k = 0; k < 24; k++) begin
         run_burst(2'($urandom_range(1, 3)), AW'($urandom), AW'($urandom_range(0, 7)),
                   AW'($urandom), AW'($urandom_range(0, 7)),
                   $urandom_range(0, 1), 1'b1);
      end

      // Reset mid-burst after two issued addresses
      req = 2'b01; start_adr0 = 6'd10; len0 = 6'd7; en = 1'b1;
      clear_q();
      gnt_exp = 2'b01;
      step();
      for (int t = 0; t < 20 && got_adr.size() < 2; t++) step();
      chk("pre_rst_issued", got_adr.size(), 2);
      #2 rst = 1'b1;
      #1 check_all_zero("async_rst");
      req = 2'b00;
      step();
      rst = 1'b0;
      prio_m = 0;
      clear_q();
      nv = 0;
      for (int t = 0; t < 6; t++) begin
         step();
         if (data_valid) nv++;
      end
      chk("valid_after_rst", nv, 0);
      run_burst(2'b10, 6'd0, 6'd0, 6'd17, 6'd2, 0, 1'b0);

      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lut_burst_arbiter.md
LUT_BURST_ARBITER -- requirements
Module: lut_burst_arbiter

Interface
REQ-001 Parameter BITWIDTH_ADR, default 6, SHALL set the LUT address width.
REQ-002 Parameter BITWIDTH_DATA, default 16, SHALL set the LUT data width.
REQ-003 CLK_SYS  in  1  SHALL be the single system clock; all state updates on the rising edge.
REQ-004 RST  in  1  SHALL be an asynchronous, active-high reset.
REQ-005 EN  in  1  SHALL allow LUT address issue when high.
REQ-006 REQ  in  2  SHALL carry one burst request bit per requester (bit0 = requester 0).
REQ-007 START_ADR0, START_ADR1  in  BITWIDTH_ADR each  SHALL give each requester's burst start address.
REQ-008 LEN0, LEN1  in  BITWIDTH_ADR each  SHALL give each requester's burst length minus one.
REQ-009 GNT  out  2  SHALL be the one-hot grant to the owning requester.
REQ-010 ROM_EN  out  1  SHALL be the LUT read enable.
REQ-011 ROM_ADR  out  BITWIDTH_ADR  SHALL be the LUT read address.
REQ-012 ROM_DATA  in  BITWIDTH_DATA  SHALL be LUT read data, valid one cycle after ROM_EN.
REQ-013 DATA_OUT  out  BITWIDTH_DATA  SHALL be the registered LUT word.
REQ-014 DATA_VALID  out  1  SHALL mark DATA_OUT valid for one cycle.
REQ-015 DATA_ID  out  1  SHALL carry the requester index owning DATA_OUT.
REQ-016 DATA_LAST  out  1  SHALL mark the final word of a burst, coincident with DATA_VALID.
REQ-017 BUSY  out  1  SHALL be high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, READ and DRAIN.
REQ-019 In IDLE with any REQ bit high, the next edge SHALL select a winner, latch its START_ADR/LEN, set GNT, and enter READ.
REQ-020 Arbitration SHALL be round-robin: on simultaneous requests, the requester not served last wins; after reset, requester 0 has priority.
REQ-021 A single active request SHALL be granted regardless of the round-robin pointer.
REQ-022 In READ with EN high, ROM_EN SHALL be 1 and ROM_ADR SHALL be start+cnt, with cnt from 0 to LEN, one word per cycle.
REQ-023 Address arithmetic SHALL be modulo 2^BITWIDTH_ADR: start+cnt wraps past the all-ones address to 0.
REQ-024 In READ with EN low, ROM_EN SHALL be 0 and cnt SHALL hold; issue resumes at the same address when EN returns high.
REQ-025 After issuing address cnt=LEN, the FSM SHALL enter DRAIN.
REQ-026 Each issued address SHALL produce DATA_VALID exactly 2 cycles later: ROM_DATA is registered into DATA_OUT.
REQ-027 DATA_LAST SHALL accompany the word for cnt=LEN.
REQ-028 LEN=0 SHALL produce a one-word burst with DATA_VALID and DATA_LAST together.
REQ-029 DRAIN SHALL last until DATA_LAST is output; the FSM SHALL then return to IDLE in the following cycle, with GNT cleared and the pointer updated.
REQ-030 GNT SHALL stay constant from grant to the end of DRAIN.
REQ-031 REQ changes during READ/DRAIN SHALL be ignored, and a granted burst SHALL always complete.
REQ-032 START_ADR/LEN changes after the grant edge SHALL not affect the running burst.
REQ-033 A request held high in IDLE after a burst SHALL be granted with no extra idle cycle beyond the single IDLE cycle.
REQ-034 DATA_VALID SHALL never be asserted for a word not issued by ROM_EN.

Reset
REQ-035 RST high SHALL immediately force IDLE, cnt=0, round-robin pointer=requester 0, and GNT=0, ROM_EN=0, ROM_ADR=0, DATA_OUT=0, DATA_VALID=0, DATA_ID=0, DATA_LAST=0, BUSY=0.
REQ-036 Reset mid-burst SHALL abort the burst, discarding in-flight pipeline words without any DATA_VALID.
REQ-037 After RST deasserts, the first grant SHALL occur on the first edge with a REQ bit high.

Verification
REQ-038 REQ=01, START_ADR0=4, LEN0=3, EN=1 -> ROM_ADR 4,5,6,7 on consecutive cycles; DATA_VALID 2 cycles after each; DATA_LAST on word 7; DATA_ID=0.
REQ-039 REQ=11 held after reset -> bursts granted 0,1,0,1 alternating; GNT one-hot and never overlapping.
REQ-040 START_ADR1=62, LEN1=3, BITWIDTH_ADR=6 -> ROM_ADR 62,63,0,1.
REQ-041 EN low for 3 cycles mid-burst after address 5 of 4..7 -> ROM_EN=0 for 3 cycles, then 6,7; 4 valid words total, no duplicates.
REQ-042 LEN0=0 -> one ROM_EN pulse; single DATA_VALID with DATA_LAST; BUSY high for 4 cycles.
REQ-043 RST pulse during READ after 2 words issued -> all outputs 0 asynchronously; no further DATA_VALID; next REQ=10 granted to requester 1.
